// File: rtl/mult_pipe_pkg.sv
// Shared constants and elaboration-time sizing helpers for the mult_pipe tree multiplier.
package mult_pipe_pkg;

  localparam int LAT = 3;

  // Number of partial-product bits landing in a given column of a width x width array.
  function automatic int pp_col_height(input int width, input int col);
    if (col < 0 || col > 2*width - 2) return 0;
    return (col < width) ? col + 1 : 2*width - 1 - col;
  endfunction

  function automatic int pp_max_height(input int width);
    int h;
    h = 0;
    for (int c = 0; c < 2*width; c++) begin
      if (pp_col_height(width, c) > h) h = pp_col_height(width, c);
    end
    return h;
  endfunction

  // Rows left after a number of 3:2 carry-save levels.
  function automatic int csa_rows(input int rows, input int levels);
    int r;
    r = rows;
    for (int i = 0; i < levels; i++) begin
      if (r > 2) r = (r / 3) * 2 + (r % 3);
    end
    return r;
  endfunction

  function automatic int csa_levels(input int rows);
    int r;
    int n;
    r = rows;
    n = 0;
    while (r > 2) begin
      r = (r / 3) * 2 + (r % 3);
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// Valid/ready operand and product streams for mult_pipe; in_signed exists only with MULT_PIPE_SIGNED_EN.
interface mult_pipe_if #(parameter int WIDTH = 8);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_x;
  logic [WIDTH-1:0]   in_y;
`ifdef MULT_PIPE_SIGNED_EN
  logic               in_signed;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

`ifdef MULT_PIPE_SIGNED_EN
  modport master (output in_valid, in_x, in_y, in_signed, out_ready,
                  input  in_ready, out_valid, out_p);
  modport slave  (input  in_valid, in_x, in_y, in_signed, out_ready,
                  output in_ready, out_valid, out_p);
`else
  modport master (output in_valid, in_x, in_y, out_ready,
                  input  in_ready, out_valid, out_p);
  modport slave  (input  in_valid, in_x, in_y, out_ready,
                  output in_ready, out_valid, out_p);
`endif

endinterface

// File: rtl/mult_prefix_add.sv
// Sklansky parallel-prefix adder, carry-in 0, sum only (carry out of the top bit is dropped).
module mult_prefix_add #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);

  localparam int L = (N > 1) ? $clog2(N) : 1;

  logic g_lv [L+1][N];
  logic p_lv [L+1][N];

  for (genvar i = 0; i < N; i++) begin : g_gp
    assign g_lv[0][i] = a_i[i] & b_i[i];
    assign p_lv[0][i] = a_i[i] ^ b_i[i];
  end

  // At level k, bits in the upper half of each 2^(k+1) block absorb the group ending just below it.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    for (genvar i = 0; i < N; i++) begin : g_bit
      localparam int J = ((i >> k) << k) - 1;
      if (((i >> k) & 1) == 1) begin : g_cell
        if ((i >> (k + 1)) == 0) begin : g_grey
          assign g_lv[k+1][i] = g_lv[k][i] | (p_lv[k][i] & g_lv[k][J]);
          assign p_lv[k+1][i] = p_lv[k][i];
        end else begin : g_black
          assign g_lv[k+1][i] = g_lv[k][i] | (p_lv[k][i] & g_lv[k][J]);
          assign p_lv[k+1][i] = p_lv[k][i] & p_lv[k][J];
        end
      end else begin : g_pass
        assign g_lv[k+1][i] = g_lv[k][i];
        assign p_lv[k+1][i] = p_lv[k][i];
      end
    end
  end

  assign sum_o[0] = p_lv[0][0];
  for (genvar i = 1; i < N; i++) begin : g_sum
    assign sum_o[i] = p_lv[0][i] ^ g_lv[L][i-1];
  end

endmodule

// File: rtl/mult_pipe.sv
// Three-stage pipelined tree multiplier with valid/ready streams.
// Define MULT_PIPE_SIGNED_EN to add per-transaction Baugh-Wooley signed mode.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_pipe_if.slave bus
);

  localparam int PW = 2*WIDTH;
`ifdef MULT_PIPE_SIGNED_EN
  localparam int NROW = pp_max_height(WIDTH) + 1;
`else
  localparam int NROW = pp_max_height(WIDTH);
`endif
  localparam int NLEV = csa_levels(NROW);

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
`ifdef MULT_PIPE_SIGNED_EN
    logic             sgn;
`endif
  } s1_t;

  typedef struct packed {
    logic [PW-1:0] sum;
    logic [PW-1:0] carry;
  } s2_t;

  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t           s1_q, s1_d, s1_in;
  s2_t           s2_q, s2_d;
  logic [PW-1:0] p_q, p_d;
  logic [PW-1:0] p_sum;
  logic          adv;

  assign adv           = !v3_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.out_p     = p_q;

  always_comb begin
    s1_in     = '0;
    s1_in.x   = bus.in_x;
    s1_in.y   = bus.in_y;
`ifdef MULT_PIPE_SIGNED_EN
    s1_in.sgn = bus.in_signed;
`endif
  end

  logic [WIDTH-1:0] pp_row [WIDTH];

  // Signed mode flips the cross terms that involve exactly one operand MSB.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_row[i][j] = s1_q.x[j] & s1_q.y[i];
`ifdef MULT_PIPE_SIGNED_EN
        if (s1_q.sgn && ((i == WIDTH-1) != (j == WIDTH-1))) pp_row[i][j] = ~pp_row[i][j];
`endif
      end
    end
  end

  logic [PW-1:0] red [NLEV+1][NROW];

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign red[0][i] = PW'(pp_row[i]) << i;
  end

`ifdef MULT_PIPE_SIGNED_EN
  assign red[0][WIDTH] = s1_q.sgn ? ((PW'(1) << WIDTH) | (PW'(1) << (PW-1))) : '0;
`endif

  // Each level packs rows in groups of three through a row of full adders; leftovers pass through.
  for (genvar l = 0; l < NLEV; l++) begin : g_lev
    localparam int RIN = csa_rows(NROW, l);
    localparam int NG  = RIN / 3;
    for (genvar r = 0; r < NROW; r++) begin : g_row
      if (r < 2*NG) begin : g_fa
        if ((r % 2) == 0) begin : g_s
          assign red[l+1][r] = red[l][3*(r/2)] ^ red[l][3*(r/2)+1] ^ red[l][3*(r/2)+2];
        end else begin : g_c
          assign red[l+1][r] = ((red[l][3*(r/2)]   & red[l][3*(r/2)+1]) |
                                (red[l][3*(r/2)]   & red[l][3*(r/2)+2]) |
                                (red[l][3*(r/2)+1] & red[l][3*(r/2)+2])) << 1;
        end
      end else if (r < 2*NG + (RIN % 3)) begin : g_thru
        assign red[l+1][r] = red[l][3*NG + r - 2*NG];
      end else begin : g_zero
        assign red[l+1][r] = '0;
      end
    end
  end

  mult_prefix_add #(.N(PW)) u_add (
    .a_i   (s2_q.sum),
    .b_i   (s2_q.carry),
    .sum_o (p_sum)
  );

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    s1_d = s1_q;
    s2_d = s2_q;
    p_d  = p_q;
    if (adv) begin
      v1_d = bus.in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      if (bus.in_valid) s1_d = s1_in;
      if (v1_q) begin
        s2_d.sum   = red[NLEV][0];
        s2_d.carry = red[NLEV][1];
      end
      if (v2_q) p_d = p_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      p_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      p_q  <= p_d;
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Directed and randomized self-checking bench for mult_pipe at WIDTH=8.
module tb_mult_pipe;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mult_pipe_if #(.WIDTH(W)) bus ();

  mult_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           s;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t tv [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.in_valid = v;
    bus.in_x     = x;
    bus.in_y     = y;
  endtask

  initial begin
    logic [2*W-1:0] sb [$];
    logic [2*W-1:0] rp;
    logic [2*W-1:0] pv;
    logic [2*W-1:0] ev;
    logic signed [2*W-1:0] sx, sy;
    logic [W-1:0]   rx, ry;
    logic           rv, rs, in_fire, out_fire;
    int             sent, cyc;

    tv.push_back('{8'h00, 8'h00, 1'b0, 16'h0000});
    tv.push_back('{8'h01, 8'h01, 1'b0, 16'h0001});
    tv.push_back('{8'h0F, 8'h10, 1'b0, 16'h00F0});
    tv.push_back('{8'hC8, 8'h03, 1'b0, 16'h0258});
    tv.push_back('{8'hFF, 8'h00, 1'b0, 16'h0000});
    tv.push_back('{8'h80, 8'h02, 1'b0, 16'h0100});
    tv.push_back('{8'h12, 8'h34, 1'b0, 16'h03A8});
    tv.push_back('{8'hAB, 8'hCD, 1'b0, 16'h88EF});
    tv.push_back('{8'h80, 8'h80, 1'b0, 16'h4000});
    tv.push_back('{8'hFF, 8'h01, 1'b0, 16'h00FF});
`ifdef MULT_PIPE_SIGNED_EN
    tv.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
    tv.push_back('{8'hFF, 8'h01, 1'b1, 16'hFFFF});
    tv.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
    tv.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
`endif

    rst_n = 1'b0;
    drive(1'b0, '0, '0);
`ifdef MULT_PIPE_SIGNED_EN
    bus.in_signed = 1'b0;
`endif
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_p",     32'(bus.out_p),     32'd0);
    chk("reset_ready", 32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;
    step();

    // 255 x 255 accepted in cycle c must show up in cycle c+3 only
    drive(1'b1, 8'hFF, 8'hFF);
    step();
    drive(1'b0, '0, '0);
    chk("lat_c1_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("lat_c2_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("lat_c3_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_c3_p",     32'(bus.out_p),     32'h0000FE01);
    step();
    chk("lat_c4_valid", 32'(bus.out_valid), 32'd0);

    for (int c = 0; c < tv.size() + 2; c++) begin
      if (c < tv.size()) begin
        drive(1'b1, tv[c].x, tv[c].y);
`ifdef MULT_PIPE_SIGNED_EN
        bus.in_signed = tv[c].s;
`endif
      end else begin
        drive(1'b0, '0, '0);
      end
      step();
      if (c >= 2) begin
        chk($sformatf("vec%0d_valid", c-2), 32'(bus.out_valid), 32'd1);
        chk($sformatf("vec%0d_p", c-2),     32'(bus.out_p),     32'(tv[c-2].p));
      end else begin
        chk($sformatf("vec_pre%0d_valid", c), 32'(bus.out_valid), 32'd0);
      end
    end
`ifdef MULT_PIPE_SIGNED_EN
    bus.in_signed = 1'b0;
`endif
    step();
    chk("vec_tail_valid", 32'(bus.out_valid), 32'd0);

    // three operands then a five-cycle stall with junk offered on the input
    bus.out_ready = 1'b0;
    drive(1'b1, 8'd5, 8'd7);
    step();
    drive(1'b1, 8'd9, 8'd9);
    step();
    drive(1'b1, 8'd100, 8'd100);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'hEE, 8'hEE);
      #1;
      chk($sformatf("stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d_ready", k), 32'(bus.in_ready),  32'd0);
      chk($sformatf("stall%0d_p", k),     32'(bus.out_p),     32'h23);
      step();
    end
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(bus.in_ready), 32'd1);
    chk("release_p0",    32'(bus.out_p),    32'h23);
    step();
    chk("release_v1", 32'(bus.out_valid), 32'd1);
    chk("release_p1", 32'(bus.out_p),     32'h51);
    step();
    chk("release_v2", 32'(bus.out_valid), 32'd1);
    chk("release_p2", 32'(bus.out_p),     32'h2710);
    step();
    chk("release_v3", 32'(bus.out_valid), 32'd0);

    // reset while three transactions are in flight
    drive(1'b1, 8'd3, 8'd3);
    step();
    drive(1'b1, 8'd4, 8'd4);
    step();
    drive(1'b1, 8'd5, 8'd5);
    step();
    drive(1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_p",     32'(bus.out_p),     32'd0);
    chk("midrst_ready", 32'(bus.in_ready),  32'd1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("postrst%0d_valid", k), 32'(bus.out_valid), 32'd0);
      step();
    end
    drive(1'b1, 8'd6, 8'd7);
    step();
    drive(1'b0, '0, '0);
    step();
    step();
    chk("postrst_new_valid", 32'(bus.out_valid), 32'd1);
    chk("postrst_new_p",     32'(bus.out_p),     32'h2A);
    step();

    // random stream with random backpressure against a scoreboard
    sent = 0;
    cyc  = 0;
    while ((sent < 300 || sb.size() != 0) && cyc < 5000) begin
      rv = (sent < 300) && ($urandom_range(0, 3) != 0);
      rx = W'($urandom);
      ry = W'($urandom);
      rs = 1'b0;
`ifdef MULT_PIPE_SIGNED_EN
      rs = $urandom_range(0, 1) == 1;
      bus.in_signed = rs;
`endif
      drive(rv, rx, ry);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      in_fire  = rv && bus.in_ready;
      out_fire = bus.out_valid && bus.out_ready;
      pv       = bus.out_p;
      step();
      if (out_fire) begin
        if (sb.size() == 0) begin
          chk("rand_extra_out", 32'd1, 32'd0);
        end else begin
          ev = sb.pop_front();
          chk("rand_p", 32'(pv), 32'(ev));
        end
      end
      if (in_fire) begin
        sx = {{W{rx[W-1]}}, rx};
        sy = {{W{ry[W-1]}}, ry};
        rp = rs ? (2*W)'(sx * sy) : (2*W)'({{W{1'b0}}, rx} * {{W{1'b0}}, ry});
        sb.push_back(rp);
        sent++;
      end
      cyc++;
    end
    chk("rand_sent",    32'(sent),      32'd300);
    chk("rand_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
